dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Synchronous data-memory responder: the target end of the memory request interface driven by the pipeline MEM stage and the block data transfer unit.
- Serves two initiator ports:
  - p0: pipeline MEM stage.
  - p1: block data transfer unit, high priority, lockable.
- Single word-wide storage array; one-cycle synchronous read latency; byte/halfword/word sizing with byte-lane writes; alignment checking.

Parameters:
- ADDR_W, 10, word-address bits; array depth = 2**ADDR_W words of 32 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- p0_addr  in  32  MEM-stage byte address
- p0_wdata  in  32  MEM-stage write data, right-aligned
- p0_rd  in  1  MEM-stage read request
- p0_wr  in  1  MEM-stage write request
- p0_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- p0_rdata  out  32  MEM-stage read data, zero-extended, right-aligned
- p0_stall  out  1  p0 request not accepted this cycle; initiator holds request
- p1_addr  in  32  block-transfer byte address
- p1_wdata  in  32  block-transfer write data
- p1_rd  in  1  block-transfer read request
- p1_wr  in  1  block-transfer write request
- p1_size  in  2  same encoding as p0_size
- p1_lock  in  1  block-transfer unit busy; p0 is locked out
- p1_rdata  out  32  block-transfer read data
- err  out  1  sticky misaligned/illegal-access flag
- err_clr  in  1  synchronous clear of err

Behaviour:
- Reset (async, asserted or mid-operation):
  - p0_rdata = 0, p1_rdata = 0, err = 0, pending-response registers cleared.
  - Array contents are NOT reset and are preserved.
  - p0_stall is combinational; it is 0 with no requests.
- Request acceptance, per cycle:
  - p1 is accepted whenever p1_rd or p1_wr is high.
  - p0 is accepted only if p1_rd = 0, p1_wr = 0 and p1_lock = 0.
  - p0_stall = (p0_rd | p0_wr) & (p1_rd | p1_wr | p1_lock).
  - At most one array access per cycle.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
- Alignment:
  - Halfword requires addr[0] = 0; word requires addr[1:0] = 0; size 11 is always illegal.
  - Illegal accepted request: no array write; response data for that read = 0; err set at the next edge.
  - err stays set until err_clr. If err_clr and a new error occur in the same cycle, err = 1 (set wins).
- Write, committed at the accepted edge:
  - Byte: wdata[7:0] into lane addr[1:0].
  - Halfword: wdata[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word: all 4 lanes.
  - Other lanes are unchanged. Little-endian: lane 0 = bits [7:0].
- Read:
  - Accepted in cycle N; data valid on the owning port's rdata during cycle N+1 (the cycle after the edge).
  - Responder registers the port id, size and addr[1:0] at acceptance, then extracts and zero-extends on the response cycle.
  - Byte: lane selected by addr[1:0] into [7:0]. Halfword: lane pair selected by addr[1] into [15:0].
  - p0_rdata / p1_rdata hold their last value until that port's next accepted read. Writes and the other port never disturb them.
- Same port, rd and wr both high: the write is performed; the read also returns the OLD contents (read-first).
- Read of an address written in the same cycle by the same port returns old data; the new data is visible from the next access.
- A stalled p0 request produces no array effect and no response; it is re-evaluated every cycle while held.
- Lock: p0 is blocked for the full p1_lock window, including idle gaps between p1 transfers. This guarantees swap atomicity.

Test Plan:
- Word write/readback: p0 write 0xDEADBEEF @0x40 size 10; next cycle p0 read @0x40 -> p0_rdata = 0xDEADBEEF one cycle after the read, held while p0 idle.
- Byte merge and extract:
  - Preload 0x11223344 @0x80, then p1 byte write 0xAA @0x82 -> word reads 0x11AA3344.
  - p1 byte read @0x83 -> p1_rdata = 0x00000011.
  - Halfword read @0x82 -> 0x000011AA.
- Misalignment:
  - p0 halfword write @0x81 -> memory unchanged, err = 1.
  - p0 word read @0x42 -> p0_rdata = 0.
  - err_clr pulse -> err = 0.
  - size 11 also sets err.
- Arbitration:
  - p0 read @0x40 and p1 read @0x80 in the same cycle -> p0_stall = 1; p1_rdata = mem[0x80] next cycle.
  - p0 held -> accepted the following cycle; p0_rdata correct one cycle after acceptance.
- Lock/atomic swap:
  - p1_lock high for 4 cycles with p1 read @0x10, idle gap, then write 0x5 @0x10.
  - p0 held requesting throughout -> p0_stall = 1 all 4 cycles; p0 then reads 0x5.
- Read-first and reset:
  - p1 rd+wr 0x77 @0x20 (old 0x66) -> p1_rdata = 0x66; next read -> 0x77.
  - Assert rst_n mid-read -> both rdata = 0, err = 0; post-reset read @0x20 returns 0x77.

Source files
------------

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response bundle between the two initiators and dmem_responder
interface dmem_responder_if;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_rd;
    logic        p0_wr;
    logic [1:0]  p0_size;
    logic [31:0] p0_rdata;
    logic        p0_stall;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_rd;
    logic        p1_wr;
    logic [1:0]  p1_size;
    logic        p1_lock;
    logic [31:0] p1_rdata;
    logic        err;
    logic        err_clr;

    modport master (
        output p0_addr, p0_wdata, p0_rd, p0_wr, p0_size,
        output p1_addr, p1_wdata, p1_rd, p1_wr, p1_size, p1_lock, err_clr,
        input  p0_rdata, p0_stall, p1_rdata, err
    );

    modport slave (
        input  p0_addr, p0_wdata, p0_rd, p0_wr, p0_size,
        input  p1_addr, p1_wdata, p1_rd, p1_wr, p1_size, p1_lock, err_clr,
        output p0_rdata, p0_stall, p1_rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - two-port data-memory responder, p1 priority with lock, sized byte-lane access
module dmem_responder #(
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic              p0_req, p1_req, p0_acc, acc;
    logic [31:0]       a_addr, a_wdata;
    logic              a_rd, a_wr, legal;
    logic [1:0]        a_size;
    logic [3:0]        be;
    logic [31:0]       wlanes;
    logic [ADDR_W-1:0] idx;
    logic              unused_addr;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rd_word;

    logic              rsp_valid, rsp_p1, rsp_bad;
    logic [1:0]        rsp_size, rsp_lsb;
    logic [31:0]       rsp_data, p0_hold, p1_hold;
    logic              err_q;

    // p1 always wins; p0 is also shut out for the whole lock window so swaps stay atomic
    always_comb begin
        p1_req = bus.p1_rd | bus.p1_wr;
        p0_req = bus.p0_rd | bus.p0_wr;
        p0_acc = p0_req & ~p1_req & ~bus.p1_lock;
        acc    = p1_req | p0_acc;
        if (p1_req) begin
            a_addr  = bus.p1_addr;
            a_wdata = bus.p1_wdata;
            a_size  = bus.p1_size;
            a_rd    = bus.p1_rd;
            a_wr    = bus.p1_wr;
        end else begin
            a_addr  = bus.p0_addr;
            a_wdata = bus.p0_wdata;
            a_size  = bus.p0_size;
            a_rd    = p0_acc & bus.p0_rd;
            a_wr    = p0_acc & bus.p0_wr;
        end
    end

    assign bus.p0_stall = p0_req & (p1_req | bus.p1_lock);
    assign idx          = a_addr[ADDR_W+1:2];
    assign unused_addr  = ^a_addr[31:ADDR_W+2];

    always_comb begin
        legal  = 1'b0;
        be     = 4'b0000;
        wlanes = a_wdata;
        case (a_size)
            2'b00: begin
                legal  = 1'b1;
                be     = 4'b0001 << a_addr[1:0];
                wlanes = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                legal  = ~a_addr[0];
                be     = a_addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                legal  = (a_addr[1:0] == 2'b00);
                be     = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    // Array has no reset; the registered read samples pre-write contents (read-first)
    always_ff @(posedge clk) begin
        if (acc && a_rd)
            rd_word <= mem[idx];
        if (acc && a_wr && legal) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    always_comb begin
        rsp_data = 32'h0;
        case (rsp_size)
            2'b00: begin
                case (rsp_lsb)
                    2'd0:    rsp_data = {24'h0, rd_word[7:0]};
                    2'd1:    rsp_data = {24'h0, rd_word[15:8]};
                    2'd2:    rsp_data = {24'h0, rd_word[23:16]};
                    default: rsp_data = {24'h0, rd_word[31:24]};
                endcase
            end
            2'b01:   rsp_data = {16'h0, rsp_lsb[1] ? rd_word[31:16] : rd_word[15:0]};
            2'b10:   rsp_data = rd_word;
            default: rsp_data = 32'h0;
        endcase
        if (rsp_bad)
            rsp_data = 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_p1    <= 1'b0;
            rsp_bad   <= 1'b0;
            rsp_size  <= 2'b00;
            rsp_lsb   <= 2'b00;
            p0_hold   <= 32'h0;
            p1_hold   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            rsp_valid <= acc & a_rd;
            rsp_p1    <= p1_req;
            rsp_bad   <= ~legal;
            rsp_size  <= a_size;
            rsp_lsb   <= a_addr[1:0];
            if (rsp_valid && !rsp_p1)
                p0_hold <= rsp_data;
            if (rsp_valid && rsp_p1)
                p1_hold <= rsp_data;
            if (acc && !legal)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

    // Response is live in the cycle after acceptance, then the hold register keeps it
    assign bus.p0_rdata = (rsp_valid && !rsp_p1) ? rsp_data : p0_hold;
    assign bus.p1_rdata = (rsp_valid &&  rsp_p1) ? rsp_data : p1_hold;
    assign bus.err      = err_q;
endmodule
